// File: rtl/compressor_error_profiler.sv
// compressor_error_profiler: drives 3:2 / 4:2 approximate compressor models with swept or streamed
// patterns and accumulates saturating error statistics against the exact popcount.
module compressor_error_profiler #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    sel,
    input  logic                    in_valid,
    input  logic [3:0]              in_x,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        samples,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        ed_sum,
    output logic signed [CNT_W-1:0] bias_sum,
    output logic [2:0]              max_ed
);
    typedef enum logic [2:0] {IDLE, SWEEP, STREAM, FLUSH, DONE} state_t;
    state_t state_q, state_d;
    logic sel_q, ready_q, busy_q, done_q, v1_q;
    logic [3:0] cnt_q;
    logic [2:0] ex_q, max_q;
    logic [1:0] ap_q;
    logic [CNT_W-1:0] samples_q, err_q, ed_q, bias_q;
    logic clr, pv, s1, s2;
    logic [3:0] x, diff;
    logic [2:0] ex, ed;
    logic [1:0] ap;
    logic [CNT_W:0] ed_w, bias_w;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? (mode ? STREAM : SWEEP) : state_q;
            SWEEP:      state_d = (cnt_q == (sel_q ? 4'hF : 4'h7)) ? FLUSH : SWEEP;
            STREAM:     state_d = (in_valid && in_last) ? FLUSH : STREAM;
            FLUSH:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end
    assign clr = start && (state_q == IDLE || state_q == DONE);
    assign pv  = (state_q == SWEEP) || (state_q == STREAM && in_valid);
    // x4 is forced low for the 3:2 compressor so it never reaches s1/s2 or the popcount
    assign x   = state_q == SWEEP ? {sel_q & cnt_q[3], cnt_q[2:0]} : {sel_q & in_x[3], in_x[2:0]};
    assign s1  = (x[0] & x[1]) | x[2] | x[3];
    assign s2  = sel_q ? ((x[2] & x[3]) | x[0] | x[1]) : (x[0] | x[1]);
    assign ap  = {1'b0, s1} + {1'b0, s2};
    assign ex  = {2'b00, x[0]} + {2'b00, x[1]} + {2'b00, x[2]} + {2'b00, x[3]};
    assign diff   = {2'b00, ap_q} - {1'b0, ex_q};
    assign ed     = diff[3] ? 3'(-diff) : diff[2:0];
    assign ed_w   = {1'b0, ed_q} + (CNT_W+1)'(ed);
    assign bias_w = {bias_q[CNT_W-1], bias_q} + {{(CNT_W-3){diff[3]}}, diff};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            {ready_q, busy_q, done_q, v1_q, sel_q} <= '0;
            cnt_q     <= '0;
            {ex_q, ap_q, max_q} <= '0;
            {samples_q, err_q, ed_q, bias_q} <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d == STREAM;
            busy_q  <= state_d inside {SWEEP, STREAM, FLUSH};
            done_q  <= state_d == DONE;
            if (clr) begin
                sel_q <= sel;
                cnt_q <= '0;
                v1_q  <= 1'b0;
                max_q <= '0;
                {samples_q, err_q, ed_q, bias_q} <= '0;
            end else begin
                cnt_q <= state_q == SWEEP ? cnt_q + 4'd1 : cnt_q;
                v1_q  <= pv;
                ex_q  <= ex;
                ap_q  <= ap;
                if (v1_q) begin
                    samples_q <= &samples_q ? samples_q : samples_q + CNT_W'(1);
                    err_q     <= (diff != 4'd0 && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
                    ed_q      <= ed_w[CNT_W] ? '1 : ed_w[CNT_W-1:0];
                    // signed overflow clamps toward the sign of the true result
                    bias_q    <= (bias_w[CNT_W] ^ bias_w[CNT_W-1]) ?
                                 {bias_w[CNT_W], {(CNT_W-1){~bias_w[CNT_W]}}} : bias_w[CNT_W-1:0];
                    max_q     <= ed > max_q ? ed : max_q;
                end
            end
        end
    end
    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign samples  = samples_q;
    assign err_cnt  = err_q;
    assign ed_sum   = ed_q;
    assign bias_sum = bias_q;
    assign max_ed   = max_q;
endmodule

// File: tb/tb_compressor_error_profiler.sv
// tb_compressor_error_profiler: directed and random sweeps/streams on 16- and 8-bit instances,
// checked against an integer model of the compressor equations with clamped statistics.
module tb_compressor_error_profiler;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, mode = 1'b0, sel = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic [3:0] in_x = 4'd0;
    logic rdy16, busy16, done16, rdy8, busy8, done8;
    logic [15:0] smp16, err16, ed16, bias16;
    logic [7:0] smp8, err8, ed8, bias8;
    logic [2:0] max16, max8;
    int total = 0, bad = 0;
    int m_n, m_err, m_ed, m_bias, m_max;
    int bx[$];
    bit bv[$], bl[$];

    compressor_error_profiler #(.CNT_W(16)) d16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_x(in_x), .in_last(in_last), .in_ready(rdy16), .busy(busy16), .done(done16),
        .samples(smp16), .err_cnt(err16), .ed_sum(ed16), .bias_sum(bias16), .max_ed(max16));
    compressor_error_profiler #(.CNT_W(8)) d8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_x(in_x), .in_last(in_last), .in_ready(rdy8), .busy(busy8), .done(done8),
        .samples(smp8), .err_cnt(err8), .ed_sum(ed8), .bias_sum(bias8), .max_ed(max8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int approx_of(int x, bit s4);
        int a = x & 1, b = (x >> 1) & 1, c = (x >> 2) & 1, d = s4 ? (x >> 3) & 1 : 0;
        return s4 ? (((a & b) | c | d) + ((c & d) | a | b)) : (((a & b) | c) + (a | b));
    endfunction

    function automatic int exact_of(int x, bit s4);
        return (x & 1) + ((x >> 1) & 1) + ((x >> 2) & 1) + (s4 ? (x >> 3) & 1 : 0);
    endfunction

    task automatic model_clear;
        m_n = 0; m_err = 0; m_ed = 0; m_bias = 0; m_max = 0;
    endtask

    task automatic model_add(input int x, input bit s4);
        int e = approx_of(x, s4) - exact_of(x, s4);
        int ae = e < 0 ? -e : e;
        m_n++;
        if (e != 0) m_err++;
        m_ed += ae;
        m_bias += e;
        if (ae > m_max) m_max = ae;
    endtask

    function automatic longint sat_u(int v, int w);
        longint top = (longint'(1) << w) - 1;
        return v > top ? top : v;
    endfunction

    function automatic longint sat_s(int v, int w);
        longint lo = -(longint'(1) << (w - 1)), hi = (longint'(1) << (w - 1)) - 1;
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    task automatic check_res(input string tag);
        chk({tag, "_samples16"}, smp16, sat_u(m_n, 16));
        chk({tag, "_err16"}, err16, sat_u(m_err, 16));
        chk({tag, "_ed16"}, ed16, sat_u(m_ed, 16));
        chk({tag, "_bias16"}, longint'($signed(bias16)), sat_s(m_bias, 16));
        chk({tag, "_max16"}, max16, m_max);
        chk({tag, "_samples8"}, smp8, sat_u(m_n, 8));
        chk({tag, "_err8"}, err8, sat_u(m_err, 8));
        chk({tag, "_ed8"}, ed8, sat_u(m_ed, 8));
        chk({tag, "_bias8"}, longint'($signed(bias8)), sat_s(m_bias, 8));
        chk({tag, "_max8"}, max8, m_max);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done16 && n < 400) begin
            tick;
            n++;
        end
        chk({tag, "_done_seen"}, done16, 1);
        chk({tag, "_done8"}, done8, 1);
        chk({tag, "_busy_off"}, busy16, 0);
    endtask

    task automatic run_sweep(input bit s, input string tag);
        int n = 1;
        model_clear;
        for (int x = 0; x < (s ? 16 : 8); x++) model_add(x, s);
        mode = 1'b0; sel = s; start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_busy"}, busy16, 1);
        chk({tag, "_cleared"}, smp16, 0);
        while (!done16 && n < 100) begin
            start = (n == 3);
            sel = (n >= 4) ? ~s : s;
            tick;
            n++;
        end
        start = 1'b0; sel = s;
        chk({tag, "_latency"}, n, s ? 18 : 10);
        chk({tag, "_ready"}, rdy16, 0);
        check_res(tag);
    endtask

    task automatic run_stream(input bit s, input string tag);
        model_clear;
        mode = 1'b1; sel = s; start = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        chk({tag, "_ready_on"}, rdy16, 1);
        foreach (bx[i]) begin
            in_valid = bv[i]; in_x = 4'(bx[i]); in_last = bl[i];
            if (bv[i]) model_add(bx[i], s);
            if (bv[i] && bl[i]) chk({tag, "_ready_last"}, rdy16, 1);
            tick;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_ready_drop"}, rdy16, 0);
        chk({tag, "_flush_busy"}, busy16, 1);
        wait_done(tag);
        check_res(tag);
    endtask

    task automatic push(input int x, input bit v, input bit l);
        bx.push_back(x); bv.push_back(v); bl.push_back(l);
    endtask

    initial begin
        tick; tick;
        rst = 1'b0;
        chk("rst_ready", rdy16, 0); chk("rst_busy", busy16, 0); chk("rst_done", done16, 0);
        chk("rst_samples", smp16, 0); chk("rst_bias", bias16, 0); chk("rst_max", max16, 0);

        run_sweep(1'b1, "sweep4");
        chk("sweep4_err_const", err16, 5); chk("sweep4_bias_const", longint'($signed(bias16)), -6);
        run_sweep(1'b0, "sweep3");
        chk("sweep3_err_const", err16, 1); chk("sweep3_ed_const", ed16, 1);

        bx.delete(); bv.delete(); bl.delete();
        push(15, 1, 0); push(0, 0, 1); push(7, 1, 0); push(3, 1, 1);
        run_stream(1'b1, "str4");
        chk("str4_samples_const", smp16, 3); chk("str4_ed_const", ed16, 3);

        bx.delete(); bv.delete(); bl.delete();
        push(15, 1, 1);
        run_stream(1'b0, "str3");
        chk("str3_err_const", err16, 1); chk("str3_max_const", max16, 1);

        mode = 1'b0; sel = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", busy16, 0); chk("midrst_done", done16, 0); chk("midrst_samples", smp16, 0);
        chk("midrst_err", err16, 0); chk("midrst_ed", ed16, 0); chk("midrst_bias", bias16, 0);
        chk("midrst_max", max16, 0); chk("midrst_samples8", smp8, 0);
        tick;
        chk("midrst_idle_samples", smp16, 0);
        run_sweep(1'b1, "post_rst");

        bx.delete(); bv.delete(); bl.delete();
        for (int i = 0; i < 300; i++) push(15, 1, i == 299);
        run_stream(1'b1, "sat");
        chk("sat_samples8", smp8, 255); chk("sat_err8", err8, 255); chk("sat_ed8", ed8, 255);
        chk("sat_bias8", longint'($signed(bias8)), -128); chk("sat_max8", max8, 2);

        for (int r = 0; r < 8; r++) begin
            int len = $urandom_range(1, 60);
            bx.delete(); bv.delete(); bl.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) push($urandom_range(0, 15), 0, $urandom_range(0, 1));
                push($urandom_range(0, 15), 1, i == len - 1);
            end
            run_stream(1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
